// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan scheduler and its channel walker.
package adc_scan_pkg;

  localparam int DATA_NUM_W      = 15;
  localparam int CH_W            = 8;
  localparam int ACK_TIMEOUT_DEF = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FIRE,
    ST_DELAY,
    ST_START,
    ST_ACK,
    ST_ACQ,
    ST_SEND,
    ST_NEXT,
    ST_GAP
  } scan_state_e;

endpackage

// File: rtl/adc_ch_rr_next.sv
// Round-robin next-set-bit finder over the channel mask; a zero current
// selection yields the lowest enabled channel without flagging a wrap.
module adc_ch_rr_next
  import adc_scan_pkg::*;
(
  input  logic [CH_W-1:0] mask,
  input  logic [CH_W-1:0] cur_onehot,
  output logic [CH_W-1:0] next_onehot,
  output logic            wrap
);

  localparam logic [CH_W-1:0] ONE = 1;

  logic [CH_W-1:0] above;

  // x & -x isolates the lowest set bit of x
  always_comb begin
    above       = (cur_onehot == '0) ? mask : (mask & ~(cur_onehot | (cur_onehot - ONE)));
    wrap        = (cur_onehot != '0) && (above == '0);
    next_onehot = '0;
    if (above != '0)
      next_onehot = above & (~above + ONE);
    else
      next_onehot = mask & (~mask + ONE);
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Per-channel shot sequencer: fire, echo delay, acquisition burst, packet send,
// then round-robin to the next enabled channel for a set number of frames.
module adc_scan_scheduler
  import adc_scan_pkg::*;
#(
  parameter int PULSE_W     = 8,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [CH_W-1:0]       cfg_ch_mask,
  input  logic [DATA_NUM_W-1:0] cfg_data_num,
  input  logic [15:0]           cfg_delay,
  input  logic [23:0]           cfg_period,
  input  logic [15:0]           cfg_frames,
  input  logic                  acq_busy,
  input  logic                  pkt_done,
  output logic                  tx_pulse,
  output logic                  RestartReq,
  output logic [CH_W-1:0]       ChannelSel,
  output logic [DATA_NUM_W-1:0] DataNum,
  output logic                  pkt_req,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  err
);

  scan_state_e     state;
  logic [CH_W-1:0] mask_q;
  logic [15:0]     delay_q;
  logic [15:0]     frames_q;
  logic [23:0]     period_q;
  logic [15:0]     step_cnt;
  logic [23:0]     period_cnt;
  logic            stop_pending;

  logic [CH_W-1:0] rr_mask;
  logic [CH_W-1:0] rr_cur;
  logic [CH_W-1:0] rr_next;
  logic            rr_wrap;
  logic [15:0]     frame_cnt_inc;
  logic [15:0]     frame_cnt_nxt;
  logic            frames_done;
  logic            stop_now;
  logic            period_ok;
  logic            delay_done;
  logic            pulse_done;
  logic            ack_expired;

  // In IDLE the walker sees the incoming mask with no current channel, giving the first shot
  assign rr_mask = (state == ST_IDLE) ? cfg_ch_mask : mask_q;
  assign rr_cur  = (state == ST_IDLE) ? '0 : ChannelSel;

  adc_ch_rr_next u_rr (
    .mask        (rr_mask),
    .cur_onehot  (rr_cur),
    .next_onehot (rr_next),
    .wrap        (rr_wrap)
  );

  assign frame_cnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
  assign frame_cnt_nxt = rr_wrap ? frame_cnt_inc : frame_cnt;
  assign frames_done   = (frames_q != 16'd0) && (frame_cnt_nxt >= frames_q);
  assign stop_now      = stop_pending | cfg_stop;
  assign period_ok     = ({1'b0, period_cnt} + 25'd1) >= {1'b0, period_q};
  assign delay_done    = ({1'b0, step_cnt} + 17'd1) >= {1'b0, delay_q};
  assign pulse_done    = step_cnt == 16'(PULSE_W - 1);
  assign ack_expired   = step_cnt == 16'(ACK_TIMEOUT - 1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      delay_q      <= '0;
      frames_q     <= '0;
      period_q     <= '0;
      step_cnt     <= '0;
      period_cnt   <= '0;
      stop_pending <= 1'b0;
      tx_pulse     <= 1'b0;
      RestartReq   <= 1'b0;
      ChannelSel   <= '0;
      DataNum      <= '0;
      pkt_req      <= 1'b0;
      busy         <= 1'b0;
      frame_cnt    <= '0;
      err          <= 1'b0;
    end else begin
      RestartReq <= 1'b0;
      step_cnt   <= step_cnt + 16'd1;
      if (period_cnt != '1)
        period_cnt <= period_cnt + 24'd1;
      if (state != ST_IDLE && cfg_stop)
        stop_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            mask_q       <= cfg_ch_mask;
            DataNum      <= cfg_data_num;
            delay_q      <= cfg_delay;
            period_q     <= cfg_period;
            frames_q     <= cfg_frames;
            frame_cnt    <= '0;
            stop_pending <= 1'b0;
            err          <= (cfg_ch_mask == '0);
            if (cfg_ch_mask != '0) begin
              ChannelSel <= rr_next;
              tx_pulse   <= 1'b1;
              busy       <= 1'b1;
              step_cnt   <= '0;
              period_cnt <= '0;
              state      <= ST_FIRE;
            end
          end
        end
        ST_FIRE: begin
          if (pulse_done) begin
            tx_pulse <= 1'b0;
            step_cnt <= '0;
            state    <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (delay_done) begin
            RestartReq <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          step_cnt <= '0;
          state    <= ST_ACK;
        end
        ST_ACK: begin
          if (acq_busy) begin
            state <= ST_ACQ;
          end else if (ack_expired) begin
            err          <= 1'b1;
            busy         <= 1'b0;
            ChannelSel   <= '0;
            stop_pending <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_ACQ: begin
          if (!acq_busy) begin
            pkt_req <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pkt_done) begin
            pkt_req <= 1'b0;
            state   <= ST_NEXT;
          end
        end
        // A wrap back to the lowest enabled channel closes a frame
        ST_NEXT: begin
          ChannelSel <= rr_next;
          frame_cnt  <= frame_cnt_nxt;
          if (stop_now || frames_done) begin
            busy         <= 1'b0;
            ChannelSel   <= '0;
            stop_pending <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (period_ok) begin
            tx_pulse   <= 1'b1;
            step_cnt   <= '0;
            period_cnt <= '0;
            state      <= ST_FIRE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with simple ADC/TX responders and
// hand-computed cycle timings.
module tb_adc_scan_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [7:0]  cfg_ch_mask = '0;
  logic [14:0] cfg_data_num = '0;
  logic [15:0] cfg_delay = '0;
  logic [23:0] cfg_period = '0;
  logic [15:0] cfg_frames = '0;
  logic        acq_busy = 1'b0;
  logic        pkt_done = 1'b0;
  logic        tx_pulse;
  logic        RestartReq;
  logic [7:0]  ChannelSel;
  logic [14:0] DataNum;
  logic        pkt_req;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err;

  adc_scan_scheduler #(.PULSE_W(8), .ACK_TIMEOUT(4)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_ch_mask  (cfg_ch_mask),
    .cfg_data_num (cfg_data_num),
    .cfg_delay    (cfg_delay),
    .cfg_period   (cfg_period),
    .cfg_frames   (cfg_frames),
    .acq_busy     (acq_busy),
    .pkt_done     (pkt_done),
    .tx_pulse     (tx_pulse),
    .RestartReq   (RestartReq),
    .ChannelSel   (ChannelSel),
    .DataNum      (DataNum),
    .pkt_req      (pkt_req),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .err          (err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  bit acq_auto = 1'b1;

  // Event log, sampled 1 time unit after each rising edge
  int         cyc = 0;
  int         tx_rises = 0;
  int         rr_rises = 0;
  int         pkt_rises = 0;
  int         rr_w = 0;
  int         rr_maxw = 0;
  int         tx_cyc[64];
  int         rr_cyc[64];
  logic [7:0] ch_fire[64];
  logic       tx_d = 1'b0;
  logic       rr_d = 1'b0;
  logic       pkt_d = 1'b0;

  always begin
    @(posedge Clk);
    #1;
    cyc++;
    if (tx_pulse && !tx_d) begin
      if (tx_rises < 64) begin
        tx_cyc[tx_rises]  = cyc;
        ch_fire[tx_rises] = ChannelSel;
      end
      tx_rises++;
    end
    if (RestartReq && !rr_d) begin
      if (rr_rises < 64) rr_cyc[rr_rises] = cyc;
      rr_rises++;
    end
    if (pkt_req && !pkt_d) pkt_rises++;
    if (RestartReq) begin
      rr_w++;
      if (rr_w > rr_maxw) rr_maxw = rr_w;
    end else begin
      rr_w = 0;
    end
    tx_d  = tx_pulse;
    rr_d  = RestartReq;
    pkt_d = pkt_req;
  end

  // Write controller model: acq_busy rises 2 cycles after RestartReq and holds 100 cycles
  always begin
    @(posedge Clk);
    #1;
    if (Reset_n && acq_auto && RestartReq) begin
      repeat (2) begin @(posedge Clk); #1; end
      acq_busy = 1'b1;
      repeat (100) begin @(posedge Clk); #1; end
      acq_busy = 1'b0;
    end
  end

  // TX path model: pkt_done pulses 20 cycles after pkt_req is first seen
  always begin
    @(posedge Clk);
    #1;
    if (Reset_n && pkt_req) begin
      repeat (20) begin @(posedge Clk); #1; end
      pkt_done = 1'b1;
      @(posedge Clk);
      #1;
      pkt_done = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // Pulses cfg_start with the given config, then scrambles the config inputs
  task automatic applyStimulus(input logic [7:0] mask, input logic [14:0] dnum,
                               input logic [15:0] dly, input logic [23:0] per,
                               input logic [15:0] frm);
    cfg_ch_mask  = mask;
    cfg_data_num = dnum;
    cfg_delay    = dly;
    cfg_period   = per;
    cfg_frames   = frm;
    cfg_start    = 1'b1;
    tick(1);
    cfg_start    = 1'b0;
    cfg_ch_mask  = 8'hFF;
    cfg_data_num = 15'd7;
    cfg_delay    = 16'd3;
    cfg_period   = 24'd1;
    cfg_frames   = 16'd9;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (busy && n < budget);
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  int tb0, rb0, pb0;

  initial begin
    $display("[TB] start");
    tick(3);
    checkOutput("rst_flags", 32'({tx_pulse, RestartReq, pkt_req, busy, err}), 32'd0);
    checkOutput("rst_chsel", 32'(ChannelSel), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_datanum", 32'(DataNum), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick(2);

    // Two channels, one frame, delay 10
    tb0 = tx_rises; rb0 = rr_rises;
    applyStimulus(8'h05, 15'd100, 16'd10, 24'd0, 16'd1);
    checkOutput("t1_busy_up", 32'(busy), 32'd1);
    waitIdle(2000, "t1_idle");
    checkOutput("t1_tx_count", 32'(tx_rises - tb0), 32'd2);
    checkOutput("t1_rr_count", 32'(rr_rises - rb0), 32'd2);
    checkOutput("t1_ch_first", 32'(ch_fire[tb0]), 32'h01);
    checkOutput("t1_ch_second", 32'(ch_fire[tb0 + 1]), 32'h04);
    checkOutput("t1_delay10", 32'(rr_cyc[rb0] - tx_cyc[tb0]), 32'd18);
    checkOutput("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("t1_err", 32'(err), 32'd0);
    checkOutput("t1_datanum", 32'(DataNum), 32'd100);
    checkOutput("t1_chsel_idle", 32'(ChannelSel), 32'd0);

    // Delay 0: one DELAY cycle after the 8-cycle pulse
    tb0 = tx_rises; rb0 = rr_rises;
    applyStimulus(8'h01, 15'd10, 16'd0, 24'd0, 16'd1);
    waitIdle(1000, "t2_idle");
    checkOutput("t2_delay0", 32'(rr_cyc[rb0] - tx_cyc[tb0]), 32'd9);
    checkOutput("t2_rr_width", 32'(rr_maxw), 32'd1);

    // Long period sets the shot spacing
    tb0 = tx_rises;
    applyStimulus(8'h01, 15'd10, 16'd0, 24'd5000, 16'd2);
    waitIdle(8000, "t3_idle");
    checkOutput("t3_tx_count", 32'(tx_rises - tb0), 32'd2);
    checkOutput("t3_spacing5000", 32'(tx_cyc[tb0 + 1] - tx_cyc[tb0]), 32'd5000);
    checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd2);

    // Short period: natural shot length 8+1+1+2+100+21+1+1
    tb0 = tx_rises;
    applyStimulus(8'h01, 15'd10, 16'd0, 24'd10, 16'd2);
    waitIdle(2000, "t3b_idle");
    checkOutput("t3b_spacing_nat", 32'(tx_cyc[tb0 + 1] - tx_cyc[tb0]), 32'd135);

    // Continuous on channel 7, stop during ACQ
    tb0 = tx_rises; pb0 = pkt_rises;
    applyStimulus(8'h80, 15'd10, 16'd0, 24'd0, 16'd0);
    begin
      int n = 0;
      while (!acq_busy && n < 100) begin tick(1); n++; end
    end
    checkOutput("t4_acq_seen", 32'(acq_busy), 32'd1);
    tick(3);
    cfg_stop = 1'b1;
    tick(1);
    cfg_stop = 1'b0;
    checkOutput("t4_still_busy", 32'(busy), 32'd1);
    waitIdle(1000, "t4_idle");
    checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("t4_pkt_count", 32'(pkt_rises - pb0), 32'd1);
    checkOutput("t4_ch", 32'(ch_fire[tb0]), 32'h80);
    tick(300);
    checkOutput("t4_no_more_tx", 32'(tx_rises - tb0), 32'd1);

    // acq_busy never rises: ACK timeout
    acq_auto = 1'b0;
    pb0 = pkt_rises;
    applyStimulus(8'h02, 15'd10, 16'd0, 24'd0, 16'd0);
    begin
      int n = 0;
      while (!RestartReq && n < 100) begin tick(1); n++; end
    end
    checkOutput("t5_rr_seen", 32'(RestartReq), 32'd1);
    tick(3);
    checkOutput("t5_err_early", 32'(err), 32'd0);
    checkOutput("t5_busy_ack", 32'(busy), 32'd1);
    tick(2);
    checkOutput("t5_err_set", 32'(err), 32'd1);
    checkOutput("t5_busy_gone", 32'(busy), 32'd0);
    tick(30);
    checkOutput("t5_no_pkt", 32'(pkt_rises - pb0), 32'd0);
    acq_auto = 1'b1;
    applyStimulus(8'h01, 15'd10, 16'd0, 24'd0, 16'd1);
    checkOutput("t5_err_cleared", 32'(err), 32'd0);
    waitIdle(1000, "t5b_idle");
    checkOutput("t5b_frame_cnt", 32'(frame_cnt), 32'd1);

    // Empty mask
    tb0 = tx_rises;
    applyStimulus(8'h00, 15'd10, 16'd0, 24'd0, 16'd1);
    checkOutput("t6_err", 32'(err), 32'd1);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    tick(5);
    checkOutput("t6_busy_later", 32'(busy), 32'd0);
    checkOutput("t6_no_tx", 32'(tx_rises - tb0), 32'd0);

    // Asynchronous reset during SEND
    applyStimulus(8'h08, 15'd10, 16'd0, 24'd0, 16'd0);
    begin
      int n = 0;
      while (!pkt_req && n < 300) begin tick(1); n++; end
    end
    checkOutput("t7_send_reached", 32'(pkt_req), 32'd1);
    checkOutput("t7_chsel_send", 32'(ChannelSel), 32'h08);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("t7_async_flags", 32'({tx_pulse, RestartReq, pkt_req, busy}), 32'd0);
    checkOutput("t7_async_chsel", 32'(ChannelSel), 32'd0);
    #3;
    Reset_n = 1'b1;
    tick(30);
    checkOutput("t7_idle_after", 32'(busy), 32'd0);
    checkOutput("t7_frame_cnt", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Sequences one ultrasonic shot per enabled ADC channel: fires the transducer pulse, waits the echo delay, then starts one acquisition burst in the ADC-to-FIFO write controller.
- After each burst it hands the filled FIFO to the RGMII packet sender and advances round-robin through the channel mask.
- Repeats for a programmed number of frames, or continuously.
- Sits between the host register file and the ADC write controller / Ethernet TX path.

Parameters:
- PULSE_W, 8, width of tx_pulse in Clk cycles (1..255).
- ACK_TIMEOUT, 4, cycles allowed for acq_busy to rise after RestartReq.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  single-cycle pulse: begin scan
- cfg_stop  in  1  single-cycle pulse: graceful stop
- cfg_ch_mask  in  8  enabled channels, bit i = channel i
- cfg_data_num  in  15  samples per burst, passed to DataNum
- cfg_delay  in  16  cycles from tx_pulse fall to RestartReq
- cfg_period  in  24  minimum cycles between successive tx_pulse rises
- cfg_frames  in  16  frames to run (one frame = all enabled channels once); 0 = continuous
- acq_busy  in  1  sample_en from the write controller
- pkt_done  in  1  single-cycle pulse from the TX path: FIFO drained
- tx_pulse  out  1  transducer fire pulse
- RestartReq  out  1  single-cycle acquisition start
- ChannelSel  out  8  one-hot active channel
- DataNum  out  15  latched sample count
- pkt_req  out  1  level: request FIFO transmit
- busy  out  1  high in any state except IDLE
- frame_cnt  out  16  frames completed this scan
- err  out  1  sticky error flag; cleared by cfg_start

Behaviour:
- Reset values: every output is 0, state is IDLE, all counters are 0.
- Config latch
  - On cfg_start in IDLE: latch mask, data_num, delay, period and frames; clear frame_cnt and err.
  - Later config changes are ignored until IDLE is re-entered.
  - cfg_start outside IDLE is ignored.
- Empty mask: if the latched mask is 0, set err and stay in IDLE.
- Channel pointer
  - The first channel is the lowest set bit of the mask.
  - The next channel is the next set bit above the current one, wrapping to the lowest set bit.
  - A wrap marks frame end.
  - ChannelSel is registered and stable from FIRE through SEND.
- FSM states:
  - IDLE
  - FIRE: tx_pulse=1 for exactly PULSE_W cycles; the period counter restarts at 0 on entry.
  - DELAY: count cfg_delay cycles. A delay of 0 gives exactly 1 cycle in DELAY.
  - START: RestartReq=1 for exactly 1 cycle.
  - ACK: wait for acq_busy=1. If it has not risen after ACK_TIMEOUT cycles: set err, go to IDLE.
  - ACQ: wait for acq_busy=0.
  - SEND: pkt_req=1 until pkt_done is sampled; pkt_req drops the cycle after pkt_done.
  - NEXT: 1 cycle. Advance the pointer. On wrap, frame_cnt++.
    - Go to IDLE if stop is pending, or if frames≠0 and frame_cnt has reached frames.
    - Otherwise go to GAP.
  - GAP: wait until period counter ≥ cfg_period-1, then go to FIRE. A period ≤ the shot length means no added gap.
- Period counter
  - 24-bit, saturating at all-ones; never wraps.
- Stop handling
  - cfg_stop sets a stop_pending flag in any non-IDLE state; the flag is honoured only in NEXT.
  - The current burst always completes and transmits.
  - cfg_stop in IDLE has no effect.
- Simultaneous events
  - cfg_stop in the NEXT cycle itself counts as pending.
  - pkt_done outside SEND is ignored.
- Mid-operation reset: Reset_n low forces all outputs to 0 immediately (asynchronous). RestartReq is never left asserted.
- frame_cnt saturates at 0xFFFF in continuous mode.

Decomposition:
- Shared package (adc_scan_pkg): state enum encoding, ACK_TIMEOUT default, width constants (DATA_NUM_W=15, CH_W=8).
- One sub-module: adc_ch_rr_next, a combinational next-set-bit finder.
  - Inputs: mask[7:0], current one-hot.
  - Outputs: next one-hot, wrap flag.
  - Lowest set bit is used when current=0.

Test Plan:
- Mask 0x05, frames=1, delay=10, data_num=100; model acq_busy high 100 cycles after RestartReq; pkt_done 20 cycles after pkt_req -> ChannelSel 0x01 then 0x04; 2 tx_pulses, 2 RestartReqs; frame_cnt=1; busy falls; err=0.
- Delay=0, PULSE_W=8 -> RestartReq exactly 9 cycles after tx_pulse rise (8 FIRE + 1 DELAY); check RestartReq is a 1-cycle pulse.
- Period=5000, short shots -> successive tx_pulse rising edges exactly 5000 cycles apart; with period=10 -> spacing equals natural shot length.
- Mask 0x80, frames=0; cfg_stop during ACQ -> current burst finishes, pkt_req/pkt_done completes, then IDLE; frame_cnt=1; no further tx_pulse.
- acq_busy held low after RestartReq -> err=1 at the 4th ACK cycle, IDLE, pkt_req never asserted; next cfg_start clears err.
- Mask 0x00 cfg_start -> err=1, busy stays 0. Separately: assert Reset_n low during SEND -> pkt_req, busy, ChannelSel drop to 0 asynchronously.
